// File: rtl/cache_controller.sv
// cache_controller: direct-mapped, write-through, no-write-allocate cache
// sitting between the CPU load/store port and a 4-word-burst data memory.
// Read hits complete combinationally. Read misses fetch the whole aligned
// line in one 128-bit transfer. Stores always go to memory and also update
// the cached word when the line is resident.
// Optional feature: define CACHE_STATS_EN to add saturating hit_count and
// miss_count outputs.
module cache_controller #(
  parameter int NUM_LINES = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [9:0]   cpu_address,
  input  logic [31:0]  cpu_data_in,
  input  logic         cpu_read,
  input  logic         cpu_write,
  output logic [31:0]  cpu_data_out,
  output logic         cpu_stall,
  output logic [9:0]   mem_address,
  output logic [31:0]  mem_data_out,
  output logic         mem_read_en,
  output logic         mem_write_en,
  input  logic [127:0] mem_data_in,
  input  logic         mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 8 - INDEX_W;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ALLOCATE = 2'd1;
  localparam logic [1:0] S_WRITE    = 2'd2;

  // Controller state and the latched memory transaction.
  logic [1:0]           state_q, state_d;
  logic [9:0]           mem_address_q, mem_address_d;
  logic [31:0]          mem_data_q, mem_data_d;
  logic                 wr_hit_q, wr_hit_d;

  // Cache arrays. Only the valid bits are reset.
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [3:0][31:0]     data_q [NUM_LINES];

  // CPU-side address decode.
  logic [TAG_W-1:0]     cpu_tag;
  logic [INDEX_W-1:0]   cpu_index;
  logic [1:0]           cpu_offset;
  logic                 hit;

  // Fields of the latched transaction address.
  logic [TAG_W-1:0]     mem_tag;
  logic [INDEX_W-1:0]   mem_index;
  logic [1:0]           mem_offset;

  // Array update strobes and raw (pre-reset-gating) CPU responses.
  logic                 fill_en;
  logic                 wr_update_en;
  logic                 stall_raw;
  logic [31:0]          data_raw;

  assign cpu_tag    = cpu_address[9:2+INDEX_W];
  assign cpu_index  = cpu_address[1+INDEX_W:2];
  assign cpu_offset = cpu_address[1:0];
  assign hit        = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);

  assign mem_tag    = mem_address_q[9:2+INDEX_W];
  assign mem_index  = mem_address_q[1+INDEX_W:2];
  assign mem_offset = mem_address_q[1:0];

  // Next-state logic and CPU response for the IDLE/ALLOCATE/WRITE controller.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d       = state_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    wr_hit_d      = wr_hit_q;
    fill_en       = 1'b0;
    wr_update_en  = 1'b0;
    stall_raw     = 1'b0;
    data_raw      = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (cpu_write) begin
          // Store wins over a simultaneous load; the load is ignored.
          state_d       = S_WRITE;
          mem_address_d = cpu_address;
          mem_data_d    = cpu_data_in;
          wr_hit_d      = hit;
          stall_raw     = 1'b1;
        end else if (cpu_read) begin
          if (hit) begin
            data_raw = data_q[cpu_index][cpu_offset];
          end else begin
            state_d       = S_ALLOCATE;
            mem_address_d = {cpu_tag, cpu_index, 2'b00};
            stall_raw     = 1'b1;
          end
        end
      end
      S_ALLOCATE: begin
        stall_raw = 1'b1;
        if (mem_ready) begin
          fill_en = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        // The store is accepted in the cycle memory acknowledges it.
        stall_raw = !mem_ready;
        if (mem_ready) begin
          wr_update_en = wr_hit_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // CPU outputs read as idle while reset is held.
  assign cpu_stall    = reset && stall_raw;
  assign cpu_data_out = reset ? data_raw : 32'h0;

  // Enables come straight from the state so reset drops them at once.
  assign mem_read_en  = (state_q == S_ALLOCATE);
  assign mem_write_en = (state_q == S_WRITE);
  assign mem_address  = mem_address_q;
  assign mem_data_out = mem_data_q;

  // Controller registers and valid bits; reset empties the cache.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      mem_address_q <= 10'h0;
      mem_data_q    <= 32'h0;
      wr_hit_q      <= 1'b0;
      valid_q       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values.
      state_q       <= state_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      wr_hit_q      <= wr_hit_d;
      if (fill_en) begin
        valid_q[mem_index] <= 1'b1;
      end
    end
  end

  // Tag and data storage: line fill on ALLOCATE completion, word update on a
  // store that hit when it was latched.
  // NOTE: the tag/data arrays have no reset; the valid bits alone qualify them.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      tag_q[mem_index]  <= mem_tag;
      data_q[mem_index] <= mem_data_in;
    end
    if (wr_update_en) begin
      data_q[mem_index][mem_offset] <= mem_data_q;
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count_q;
  logic [15:0] miss_count_q;
  logic        filled_q;
  logic        read_hit_acc;
  logic        miss_start;

  // The hit that completes a refilled read is not a separate cache hit.
  assign read_hit_acc = (state_q == S_IDLE) && !cpu_write && cpu_read && hit && !filled_q;
  assign miss_start   = (state_q == S_IDLE) && !cpu_write && cpu_read && !hit;

  // Saturating hit/miss counters; stores are not counted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= 16'h0;
      miss_count_q <= 16'h0;
      filled_q     <= 1'b0;
    end else begin
      filled_q <= fill_en;
      if (read_hit_acc && (hit_count_q != 16'hFFFF)) begin
        hit_count_q <= hit_count_q + 16'h1;
      end
      if (miss_start && (miss_count_q != 16'hFFFF)) begin
        miss_count_q <= miss_count_q + 16'h1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: randomized scoreboard bench for cache_controller.
// The driver predicts each memory transaction and load result from a
// line-residency table plus a flat word memory; a monitor pops and compares
// whenever the DUT starts a memory transaction or completes a load.
module tb_cache_controller;

  localparam int NUM_LINES = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic [9:0]   cpu_address;
  logic [31:0]  cpu_data_in;
  logic         cpu_read;
  logic         cpu_write;
  logic [31:0]  cpu_data_out;
  logic         cpu_stall;
  logic [9:0]   mem_address;
  logic [31:0]  mem_data_out;
  logic         mem_read_en;
  logic         mem_write_en;
  logic [127:0] mem_data_in;
  logic         mem_ready;
`ifdef CACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  cache_controller #(.NUM_LINES(NUM_LINES)) dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_address  (cpu_address),
    .cpu_data_in  (cpu_data_in),
    .cpu_read     (cpu_read),
    .cpu_write    (cpu_write),
    .cpu_data_out (cpu_data_out),
    .cpu_stall    (cpu_stall),
    .mem_address  (mem_address),
    .mem_data_out (mem_data_out),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_data_in  (mem_data_in),
    .mem_ready    (mem_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clock = ~clock;

  typedef enum logic [1:0] {EV_FETCH, EV_WRITE, EV_READ} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [9:0]  addr;
    logic [31:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] dram      [1024];  // the memory the responder serves
  logic [31:0] model_mem [1024];  // the reference model's view of memory
  int          resident  [NUM_LINES];  // line number held per set, -1 = empty
  int          model_hits;
  int          model_misses;
  int          lat_fix;
  int          resp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Memory responder: random 1..4 cycle latency, serves fills and absorbs stores.
  initial begin
    mem_ready   = 1'b0;
    mem_data_in = '0;
    resp_cnt    = 0;
    forever begin
      @(posedge clock);
      #1;
      mem_ready = 1'b0;
      if (!reset) begin
        resp_cnt = 0;
      end else if (mem_read_en || mem_write_en) begin
        if (resp_cnt == 0) resp_cnt = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_ready = 1'b1;
          if (mem_read_en) begin
            for (int w = 0; w < 4; w++) begin
              mem_data_in[w*32 +: 32] = dram[(int'(mem_address) / 4) * 4 + w];
            end
          end else begin
            dram[mem_address] = mem_data_out;
          end
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  task automatic take(input ev_kind_e k, output ev_t e, output bit ok);
    e.kind = k;
    e.addr = 10'h0;
    e.data = 32'h0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      ok = 1'b0;
      $display("FAIL %s_unexpected: DUT event with empty scoreboard, required no event", k.name());
    end else begin
      e = exp_q.pop_front();
      ok = (e.kind == k);
      check("event_kind", 32'(k), 32'(e.kind));
    end
  endtask

  // Monitor: compares DUT activity against the scoreboard on falling edges.
  initial begin
    logic       prev_rd;
    logic       prev_wr;
    logic [9:0] cur_rd_addr;
    logic [9:0] cur_wr_addr;
    logic [31:0] cur_wr_data;
    ev_t        e;
    bit         ok;
    prev_rd = 1'b0;
    prev_wr = 1'b0;
    cur_rd_addr = 10'h0;
    cur_wr_addr = 10'h0;
    cur_wr_data = 32'h0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_rd = 1'b0;
        prev_wr = 1'b0;
      end else begin
        check("enables_exclusive", {31'b0, mem_read_en & mem_write_en}, 32'h0);
        if (mem_read_en && !prev_rd) begin
          take(EV_FETCH, e, ok);
          cur_rd_addr = e.addr;
          if (ok) check("fetch_address", {22'b0, mem_address}, {22'b0, e.addr});
        end
        if (mem_read_en && mem_ready) begin
          check("fetch_address_stable", {22'b0, mem_address}, {22'b0, cur_rd_addr});
        end
        if (mem_write_en && !prev_wr) begin
          take(EV_WRITE, e, ok);
          cur_wr_addr = e.addr;
          cur_wr_data = e.data;
          if (ok) begin
            check("write_address", {22'b0, mem_address}, {22'b0, e.addr});
            check("write_data", mem_data_out, e.data);
          end
        end
        if (mem_write_en && mem_ready) begin
          check("write_address_stable", {22'b0, mem_address}, {22'b0, cur_wr_addr});
          check("write_data_stable", mem_data_out, cur_wr_data);
        end
        if (cpu_read && !cpu_write && !cpu_stall) begin
          take(EV_READ, e, ok);
          if (ok) check("read_data", cpu_data_out, e.data);
        end
        if (!cpu_read && !cpu_write) begin
          check("idle_stall", {31'b0, cpu_stall}, 32'h0);
          check("idle_data", cpu_data_out, 32'h0);
        end
        prev_rd = mem_read_en;
        prev_wr = mem_write_en;
      end
    end
  end

  task automatic wait_accept(input string what);
    bit done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clock);
      if (!cpu_stall) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: cpu_stall still 1 after 64 cycles, required 0", what);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_read(input logic [9:0] a);
    ev_t e;
    int  set  = (int'(a) / 4) % NUM_LINES;
    int  line = int'(a) / 4;
    if (resident[set] != line) begin
      e.kind = EV_FETCH;
      e.addr = 10'(line * 4);
      e.data = 32'h0;
      exp_q.push_back(e);
      resident[set] = line;
      model_misses++;
    end else begin
      model_hits++;
    end
    e.kind = EV_READ;
    e.addr = a;
    e.data = model_mem[a];
    exp_q.push_back(e);
    cpu_address = a;
    cpu_read    = 1'b1;
    cpu_write   = 1'b0;
    wait_accept("read");
    cpu_read = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic with_read);
    ev_t e;
    e.kind = EV_WRITE;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
    model_mem[a] = d;
    cpu_address = a;
    cpu_data_in = d;
    cpu_write   = 1'b1;
    cpu_read    = with_read;
    wait_accept("write");
    cpu_write = 1'b0;
    cpu_read  = 1'b0;
  endtask

  task automatic random_ops(input int n);
    logic [9:0] a;
    for (int i = 0; i < n; i++) begin
      a = {2'($urandom_range(0, 3)), 2'b00, 6'($urandom)};
      if ($urandom_range(0, 9) < 7) do_read(a);
      else do_write(a, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clock);
        #1;
      end
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef CACHE_STATS_EN
    check({tag, "_hit_count"}, {16'b0, hit_count}, 32'(model_hits));
    check({tag, "_miss_count"}, {16'b0, miss_count}, 32'(model_misses));
`else
    if (tag.len() == 0) $display("stats disabled");
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int i = 0; i < 1024; i++) begin
      dram[i] = $urandom;
    end
    for (int i = 0; i < 4; i++) dram[16 + i] = 32'hA0 + 32'(i);
    for (int i = 0; i < 1024; i++) model_mem[i] = dram[i];
    for (int s = 0; s < NUM_LINES; s++) resident[s] = -1;
    model_hits   = 0;
    model_misses = 0;
    lat_fix      = 0;
    reset        = 1'b0;
    cpu_address  = 10'h0;
    cpu_data_in  = 32'h0;
    cpu_read     = 1'b0;
    cpu_write    = 1'b0;

    #12;
    check("rst_mem_read_en", {31'b0, mem_read_en}, 32'h0);
    check("rst_mem_write_en", {31'b0, mem_write_en}, 32'h0);
    check("rst_mem_address", {22'b0, mem_address}, 32'h0);
    check("rst_mem_data_out", mem_data_out, 32'h0);
    check("rst_cpu_stall", {31'b0, cpu_stall}, 32'h0);
    check("rst_cpu_data_out", cpu_data_out, 32'h0);
    check_stats("rst");
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Cold miss, then a hit in the same line.
    do_read(10'h011);
    do_read(10'h013);
    // Write hit followed by a read of the updated word.
    do_write(10'h012, 32'hDEADBEEF, 1'b0);
    do_read(10'h012);
    // Conflict eviction in set 4.
    do_read(10'h050);
    do_read(10'h010);
    // Write miss never allocates.
    do_write(10'h200, 32'h12345678, 1'b0);
    do_read(10'h200);
    // Simultaneous load and store: the store wins.
    do_write(10'h013, 32'h00000055, 1'b1);
    do_read(10'h013);
    repeat (2) begin
      @(posedge clock);
      #1;
    end

    random_ops(300);
    check_stats("pre_reset");

    // Reset in the middle of a line fill.
    lat_fix = 4;
    do_read_start: begin
      ev_t e;
      e.kind = EV_FETCH; e.addr = 10'h3C4; e.data = 32'h0;
      exp_q.push_back(e);
      e.kind = EV_READ;  e.addr = 10'h3C5; e.data = model_mem[10'h3C5];
      exp_q.push_back(e);
      cpu_address = 10'h3C5;
      cpu_read    = 1'b1;
    end
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge clock);
      if (mem_read_en) seen = 1'b1;
    end
    check("midfill_fetch_started", {31'b0, seen}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("midfill_read_en", {31'b0, mem_read_en}, 32'h0);
    check("midfill_write_en", {31'b0, mem_write_en}, 32'h0);
    check("midfill_stall", {31'b0, cpu_stall}, 32'h0);
    check("midfill_data", cpu_data_out, 32'h0);
    cpu_read = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    for (int s = 0; s < NUM_LINES; s++) resident[s] = -1;
    model_hits   = 0;
    model_misses = 0;
    check_stats("post_reset");
    repeat (2) @(posedge clock);
    #1;
    reset   = 1'b1;
    lat_fix = 0;
    @(posedge clock);
    #1;

    // Lines cached before reset must miss again.
    do_read(10'h010);
    do_read(10'h013);
    do_read(10'h3C5);
    random_ops(60);
    check_stats("final");

    repeat (3) @(posedge clock);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
